// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter sharing one KFSDRAM user port
// between NUM_PORTS requesters. It owns the controller request/flag
// handshake, passes write/read words through, and aborts any transaction
// whose flag edge does not arrive within TIMEOUT_CYCLES.
module sdram_port_arbiter #(
  parameter int NUM_PORTS        = 3,
  parameter int sdram_col_width  = 10,
  parameter int sdram_row_width  = 13,
  parameter int sdram_bank_width = 2,
  parameter int sdram_data_width = 16,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int AW = sdram_col_width + sdram_row_width + sdram_bank_width
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  // requester side
  input  logic [NUM_PORTS-1:0]                    port_req,
  input  logic [NUM_PORTS-1:0]                    port_write,
  input  logic [NUM_PORTS*AW-1:0]                 port_address,
  input  logic [NUM_PORTS*sdram_col_width-1:0]    port_access_num,
  input  logic [NUM_PORTS*sdram_data_width-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]                    port_grant,
  output logic [NUM_PORTS-1:0]                    port_wdata_ack,
  output logic [sdram_data_width-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]                    port_rdata_valid,
  output logic [NUM_PORTS-1:0]                    port_done,
  output logic [NUM_PORTS-1:0]                    port_error,
  // KFSDRAM user port
  output logic [AW-1:0]                           mem_address,
  output logic [sdram_col_width-1:0]              mem_access_num,
  output logic [sdram_data_width-1:0]             mem_data_in,
  output logic                                    mem_write_request,
  output logic                                    mem_read_request,
  input  logic [sdram_data_width-1:0]             mem_data_out,
  input  logic                                    mem_write_flag,
  input  logic                                    mem_read_flag,
  input  logic                                    mem_idle
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = sdram_col_width;
  localparam int DW = sdram_data_width;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [PW-1:0]     ptr;        // first port considered in the next arbitration
  logic [PW-1:0]     pick;       // arbitration result this cycle
  logic              pick_valid;
  logic [PW-1:0]     winner;     // owner of the current transaction
  logic [NUM_PORTS-1:0] winner_oh;
  logic [NUM_PORTS-1:0] grant;

  logic [AW-1:0]     addr_q;
  logic [CW-1:0]     num_q;
  logic              write_q;
  logic              req_q;
  logic              err_q;
  logic [WW-1:0]     wd_cnt;
  logic              wd_hit;
  logic              flag;

  // Per-port views of the flattened request buses.
  logic [AW-1:0]     addr_arr  [NUM_PORTS];
  logic [CW-1:0]     num_arr   [NUM_PORTS];
  logic [DW-1:0]     wdata_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = port_address[p*AW +: AW];
    assign num_arr[p]   = port_access_num[p*CW +: CW];
    assign wdata_arr[p] = port_wdata[p*DW +: DW];
  end

  // The flag that matters depends on the direction latched at grant time.
  assign flag      = write_q ? mem_write_flag : mem_read_flag;
  assign wd_hit    = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign winner_oh = NUM_PORTS'(1) << winner;

  // Round-robin pick: first requesting port at or after ptr, wrapping.
  always_comb begin
    logic [PW:0] idx;
    // NOTE: every combinationally assigned variable gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (port_req[idx[PW-1:0]]) begin
        pick       = idx[PW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: handshake progress, zero-length and watchdog aborts.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        // A controller still busy from an aborted transaction holds us here.
        if (mem_idle && pick_valid) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (num_q == '0)  next_state = S_DONE;
        else if (flag)    next_state = S_XFER;
        else if (wd_hit)  next_state = S_DONE;
      end
      S_XFER: begin
        if (!flag)        next_state = S_DONE;
        else if (wd_hit)  next_state = S_DONE;
      end
      S_DONE:             next_state = S_IDLE;
      default:            next_state = S_IDLE;
    endcase
  end

  // Transaction datapath: winner capture, grant, request, error, pointer.
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: only control and interface registers exist here, so all of them
    // take the asynchronous reset; outputs must read 0 during reset.
    if (reset) begin
      ptr     <= '0;
      winner  <= '0;
      grant   <= '0;
      addr_q  <= '0;
      num_q   <= '0;
      write_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && next_state == S_ISSUE) begin
        winner  <= pick;
        grant   <= NUM_PORTS'(1) << pick;
        addr_q  <= addr_arr[pick];
        num_q   <= num_arr[pick];
        write_q <= port_write[pick];
        err_q   <= 1'b0;
      end
      // Entering DONE: release the grant; anything other than a clean
      // falling flag in XFER is an abort.
      if (state != S_DONE && next_state == S_DONE) begin
        grant <= '0;
        err_q <= (state == S_ISSUE) || flag;
      end
      // Request rises the cycle after ISSUE is entered and falls as soon as
      // the flag is seen or the transaction is abandoned.
      req_q <= (state == S_ISSUE) && (next_state == S_ISSUE);
      if (state == S_DONE) begin
        ptr <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // Watchdog: counts cycles spent in ISSUE or XFER, restarting on entry.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (next_state != state) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE || state == S_XFER) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Output decode: completion pulses, per-word strobes and write-data mux.
  always_comb begin
    port_done        = '0;
    port_error       = '0;
    mem_data_in      = '0;
    if (state == S_DONE) begin
      port_done  = winner_oh;
      port_error = err_q ? winner_oh : '0;
    end
    port_wdata_ack   = grant & {NUM_PORTS{mem_write_flag}};
    port_rdata_valid = grant & {NUM_PORTS{mem_read_flag}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      mem_data_in = mem_data_in | (wdata_arr[p] & {DW{grant[p]}});
    end
    mem_write_request = req_q & write_q;
    mem_read_request  = req_q & ~write_q;
  end

  assign port_grant     = grant;
  assign port_rdata     = mem_data_out;
  assign mem_address    = addr_q;
  assign mem_access_num = num_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a small KFSDRAM behavioural model plus a
// scoreboard of expected write words, read words and completions.
module tb_sdram_port_arbiter;

  localparam int NP = 3;
  localparam int CW = 10;
  localparam int RW = 13;
  localparam int BW = 2;
  localparam int DW = 16;
  localparam int AW = CW + RW + BW;
  localparam int TO = 16;

  logic              CLK = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_req;
  logic [NP-1:0]     port_write;
  logic [NP*AW-1:0]  port_address;
  logic [NP*CW-1:0]  port_access_num;
  logic [NP*DW-1:0]  port_wdata;
  logic [NP-1:0]     port_grant;
  logic [NP-1:0]     port_wdata_ack;
  logic [DW-1:0]     port_rdata;
  logic [NP-1:0]     port_rdata_valid;
  logic [NP-1:0]     port_done;
  logic [NP-1:0]     port_error;
  logic [AW-1:0]     mem_address;
  logic [CW-1:0]     mem_access_num;
  logic [DW-1:0]     mem_data_in;
  logic              mem_write_request;
  logic              mem_read_request;
  logic [DW-1:0]     mem_data_out;
  logic              mem_write_flag;
  logic              mem_read_flag;
  logic              mem_idle;

  sdram_port_arbiter #(
    .NUM_PORTS        (NP),
    .sdram_col_width  (CW),
    .sdram_row_width  (RW),
    .sdram_bank_width (BW),
    .sdram_data_width (DW),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .port_req          (port_req),
    .port_write        (port_write),
    .port_address      (port_address),
    .port_access_num   (port_access_num),
    .port_wdata        (port_wdata),
    .port_grant        (port_grant),
    .port_wdata_ack    (port_wdata_ack),
    .port_rdata        (port_rdata),
    .port_rdata_valid  (port_rdata_valid),
    .port_done         (port_done),
    .port_error        (port_error),
    .mem_address       (mem_address),
    .mem_access_num    (mem_access_num),
    .mem_data_in       (mem_data_in),
    .mem_write_request (mem_write_request),
    .mem_read_request  (mem_read_request),
    .mem_data_out      (mem_data_out),
    .mem_write_flag    (mem_write_flag),
    .mem_read_flag     (mem_read_flag),
    .mem_idle          (mem_idle)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- model
  // Controller: one latency cycle after the request, the flag is held for
  // access_num cycles; read word k carries 0x0011*(k+1). In stall mode the
  // flag never rises and mem_idle stays low until stall is released.
  typedef enum {M_IDLE, M_LAT, M_BURST, M_TAIL, M_HANG} m_state_t;
  m_state_t        m_st;
  logic [AW-1:0]   m_addr;
  logic [CW-1:0]   m_num;
  logic [CW-1:0]   m_left;
  logic            m_wr;
  int              m_idx;
  int              m_reqs;
  bit              stall;

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_st <= M_IDLE; mem_write_flag <= 1'b0; mem_read_flag <= 1'b0;
      mem_idle <= 1'b1; mem_data_out <= '0; m_left <= '0; m_idx <= 0;
      m_addr <= '0; m_num <= '0; m_wr <= 1'b0; m_reqs <= 0;
    end else begin
      case (m_st)
        M_IDLE: if (mem_write_request || mem_read_request) begin
          m_addr <= mem_address; m_num <= mem_access_num;
          m_wr <= mem_write_request; m_left <= mem_access_num;
          mem_idle <= 1'b0; m_reqs <= m_reqs + 1;
          m_st <= stall ? M_HANG : M_LAT;
        end
        M_LAT: begin
          if (m_wr) mem_write_flag <= 1'b1;
          else begin mem_read_flag <= 1'b1; mem_data_out <= 16'h0011; end
          m_idx <= 1; m_left <= m_left - 1'b1; m_st <= M_BURST;
        end
        M_BURST: if (m_left == '0) begin
          mem_write_flag <= 1'b0; mem_read_flag <= 1'b0; m_st <= M_TAIL;
        end else begin
          mem_data_out <= 16'(17 * (m_idx + 1));
          m_idx <= m_idx + 1; m_left <= m_left - 1'b1;
        end
        M_TAIL: begin mem_idle <= 1'b1; m_st <= M_IDLE; end
        M_HANG: if (!stall) begin mem_idle <= 1'b1; m_st <= M_IDLE; end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- scoreboard
  typedef struct { int port; int val; } exp_t;
  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t done_q[$];

  int            total, bad;
  int            done_cnt, req_cyc;
  int            grant_cyc [NP];
  bit            onehot_bad, sb_en;
  logic [NP-1:0] hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input bit wr, input logic [AW-1:0] addr,
                          input logic [CW-1:0] num, input logic [DW-1:0] wd);
    port_write[p] = wr;
    port_address[p*AW +: AW] = addr;
    port_access_num[p*CW +: CW] = num;
    port_wdata[p*DW +: DW] = wd;
  endtask

  // One cycle: sample at the falling edge and score whatever the DUT shows.
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if ($countones(port_grant) > 1 || $countones(port_rdata_valid) > 1 ||
        $countones(port_done) > 1) onehot_bad = 1'b1;
    for (int p = 0; p < NP; p++) if (port_grant[p]) grant_cyc[p]++;
    if (mem_write_request || mem_read_request) req_cyc++;
    if (sb_en) begin
      if (port_wdata_ack != '0) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'(port_wdata_ack), 0);
        else begin
          e = wr_q.pop_front();
          check("wr_ack_port", 32'(port_wdata_ack), 32'(1 << e.port));
          check("wr_word", 32'(mem_data_in), 32'(e.val));
        end
      end
      if (port_rdata_valid != '0) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(port_rdata_valid), 0);
        else begin
          e = rd_q.pop_front();
          check("rd_valid_port", 32'(port_rdata_valid), 32'(1 << e.port));
          check("rd_word", 32'(port_rdata), 32'(e.val));
        end
      end
      if (port_done != '0) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(port_done), 0);
        else begin
          e = done_q.pop_front();
          check("done_port", 32'(port_done), 32'(1 << e.port));
          check("done_err", 32'(port_error), (e.val != 0) ? 32'(1 << e.port) : 0);
        end
        done_cnt++;
      end
    end
    // Requesters drop their level request on their own done pulse.
    port_req = port_req & ~(port_done & ~hold);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int target;
    int k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin tick(); k++; end
    check("wait_done", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g0, rc, mr;
    bit found;
    total = 0; bad = 0; done_cnt = 0; req_cyc = 0; onehot_bad = 0;
    for (int p = 0; p < NP; p++) grant_cyc[p] = 0;
    sb_en = 1; hold = '0; stall = 0;
    reset = 1'b1; port_req = '0; port_write = '0; port_address = '0;
    port_access_num = '0; port_wdata = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_grant", 32'(port_grant), 0);
    check("rst_done", 32'(port_done), 0);
    check("rst_error", 32'(port_error), 0);
    check("rst_wreq", 32'(mem_write_request), 0);
    check("rst_rreq", 32'(mem_read_request), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_num", 32'(mem_access_num), 0);
    check("rst_wdata", 32'(mem_data_in), 0);
    reset = 1'b0;
    repeat (3) tick();

    // Three simultaneous, continuous one-word reads: service 0,1,2,0.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(32'h100 * (p + 1)), 1, '0);
    foreach (done_q[i]) ;
    done_q.push_back('{0, 0}); done_q.push_back('{1, 0});
    done_q.push_back('{2, 0}); done_q.push_back('{0, 0});
    rd_q.push_back('{0, 16'h0011}); rd_q.push_back('{1, 16'h0011});
    rd_q.push_back('{2, 16'h0011}); rd_q.push_back('{0, 16'h0011});
    hold = 3'b111; port_req = 3'b111;
    wait_dones(4, 200);
    port_req = '0; hold = '0;
    repeat (4) tick();

    // Port 1 one-word write with latency checks.
    set_port(1, 1'b1, 25'h0400400, 1, 16'h00AB);
    wr_q.push_back('{1, 16'h00AB}); done_q.push_back('{1, 0});
    port_req[1] = 1'b1;
    tick();
    check("wr_grant", 32'(port_grant), 32'b010);
    check("wr_req_before", 32'(mem_write_request), 0);
    tick();
    check("wr_req_after", 32'(mem_write_request), 1);
    check("wr_mem_addr", 32'(mem_address), 32'h0400400);
    wait_dones(1, 100);
    check("wr_req_low_at_done", 32'(mem_write_request), 0);
    check("wr_ctrl_addr", 32'(m_addr), 32'h0400400);
    check("wr_ctrl_num", 32'(m_num), 1);
    check("wr_ctrl_dir", 32'(m_wr), 1);
    repeat (3) tick();

    // Port 0 four-word read.
    set_port(0, 1'b0, 25'h1234567, 4, '0);
    for (int k = 0; k < 4; k++) rd_q.push_back('{0, 17 * (k + 1)});
    done_q.push_back('{0, 0});
    port_req[0] = 1'b1;
    wait_dones(1, 100);
    check("rd4_ctrl_num", 32'(m_num), 4);
    check("rd4_ctrl_addr", 32'(m_addr), 32'h1234567);
    repeat (3) tick();

    // Zero-length on port 2: no controller request, done+error 2 cycles on.
    set_port(2, 1'b0, 25'h0000042, 0, '0);
    mr = m_reqs; rc = req_cyc;
    done_q.push_back('{2, 1});
    port_req[2] = 1'b1;
    tick();
    check("zero_grant", 32'(port_grant), 32'b100);
    check("zero_no_early_done", 32'(port_done), 0);
    tick();
    check("zero_done", 32'(port_done), 32'b100);
    check("zero_error", 32'(port_error), 32'b100);
    check("zero_grant_released", 32'(port_grant), 0);
    repeat (3) tick();
    check("zero_no_ctrl_req", 32'(m_reqs - mr), 0);
    check("zero_no_req_cycles", 32'(req_cyc - rc), 0);

    // Watchdog: flag never rises. Grant lasts TO cycles, the request one
    // fewer because it rises a cycle after grant.
    stall = 1;
    set_port(0, 1'b0, 25'h0AAAAAA, 2, '0);
    done_q.push_back('{0, 1});
    g0 = grant_cyc[0]; rc = req_cyc;
    port_req[0] = 1'b1;
    wait_dones(1, 100);
    check("to_grant_cycles", 32'(grant_cyc[0] - g0), TO);
    check("to_req_cycles", 32'(req_cyc - rc), TO - 1);
    check("to_req_dropped", 32'(mem_read_request), 0);
    set_port(1, 1'b1, 25'h0000100, 1, 16'h5A5A);
    wr_q.push_back('{1, 16'h5A5A}); done_q.push_back('{1, 0});
    port_req[1] = 1'b1;
    repeat (6) tick();
    check("to_grant_blocked", 32'(port_grant), 0);
    stall = 0;
    wait_dones(1, 100);
    check("to_after_ctrl_addr", 32'(m_addr), 32'h0000100);
    repeat (3) tick();

    // Reset during XFER of a port 2 burst, then port 0 wins first.
    sb_en = 0;
    set_port(2, 1'b0, 25'h0000200, 8, '0);
    port_req = 3'b100;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (mem_read_flag) found = 1;
    end
    check("rst_reached_xfer", 32'(found), 1);
    @(posedge CLK);
    #2;
    reset = 1'b1; port_req = '0;
    #1;
    check("midrst_grant", 32'(port_grant), 0);
    check("midrst_rreq", 32'(mem_read_request), 0);
    check("midrst_done", 32'(port_done), 0);
    check("midrst_rvalid", 32'(port_rdata_valid), 0);
    tick(); tick();
    reset = 1'b0;
    sb_en = 1;
    tick();
    set_port(0, 1'b0, 25'h0000300, 1, '0);
    set_port(2, 1'b0, 25'h0000400, 1, '0);
    done_q.push_back('{0, 0}); done_q.push_back('{2, 0});
    rd_q.push_back('{0, 16'h0011}); rd_q.push_back('{2, 16'h0011});
    port_req = 3'b101;
    tick();
    check("postrst_first_grant", 32'(port_grant), 32'b001);
    wait_dones(2, 200);
    repeat (3) tick();

    check("sb_drained", 32'(wr_q.size() + rd_q.size() + done_q.size()), 0);
    check("onehot_outputs", 32'(onehot_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Round-robin arbiter that shares one KFSDRAM controller user port between NUM_PORTS requesters, e.g. a display fetcher, a test sequencer and a host bridge.
- Sits between the requesters and KFSDRAM in the sdram_clock domain.
- Owns the controller's request/flag handshake, so requesters only see grant, per-word acks and completion.
- Adds a per-transaction watchdog so a stalled controller cannot hang a requester forever.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- sdram_col_width, 10, column address bits; also the width of access_num.
- sdram_row_width, 13, row address bits.
- sdram_bank_width, 2, bank address bits.
- sdram_data_width, 16, data word width.
- TIMEOUT_CYCLES, 1024, cycles allowed for a flag edge before the transaction is aborted.
- Derived: AW = col+row+bank widths.

Ports:
- CLK  in  1  clock (the 100 MHz sdram_clock).
- reset  in  1  reset, asynchronous, active-high.
- port_req  in  NUM_PORTS  level request; held until that port's done pulse.
- port_write  in  NUM_PORTS  1 = write, 0 = read.
- port_address  in  NUM_PORTS*AW  start address per port.
- port_access_num  in  NUM_PORTS*col  word count per port.
- port_wdata  in  NUM_PORTS*data  write word per port.
- port_grant  out  NUM_PORTS  one-hot owner of the controller.
- port_wdata_ack  out  NUM_PORTS  current write word consumed; port presents the next word on the following cycle.
- port_rdata  out  data  read word, broadcast to all ports.
- port_rdata_valid  out  NUM_PORTS  port_rdata valid for the granted port.
- port_done  out  NUM_PORTS  1-cycle completion pulse.
- port_error  out  NUM_PORTS  1-cycle pulse, coincident with done, on abort.
- mem_address  out  AW  to KFSDRAM.
- mem_access_num  out  col  to KFSDRAM.
- mem_data_in  out  data  to KFSDRAM.
- mem_write_request  out  1  to KFSDRAM.
- mem_read_request  out  1  to KFSDRAM.
- mem_data_out  in  data  from KFSDRAM.
- mem_write_flag  in  1  from KFSDRAM.
- mem_read_flag  in  1  from KFSDRAM.
- mem_idle  in  1  from KFSDRAM.

Behaviour:
- Reset: every output 0; FSM in IDLE; round-robin pointer at port 0; watchdog cleared.
- States:
  - IDLE: if mem_idle and any port_req is high, pick the first requesting port at or after the pointer (wrapping). Register its address, access_num and write bit. Set that port's grant. Go to ISSUE next cycle.
  - ISSUE: assert mem_write_request or mem_read_request. Wait for the matching flag to go high, then drop the request and go to XFER.
  - XFER: wait for the flag to go low, then go to DONE.
  - DONE: pulse port_done for one cycle, clear grant, set pointer = winner+1 mod NUM_PORTS, return to IDLE.
- Latency: req sampled in IDLE -> grant 1 cycle later -> request asserted the cycle after that.
- Write data:
  - mem_data_in = port_wdata of the granted port, combinational mux.
  - port_wdata_ack[g] = mem_write_flag & grant[g].
- Read data:
  - port_rdata = mem_data_out.
  - port_rdata_valid[g] = mem_read_flag & grant[g].
- mem_address and mem_access_num are held stable from ISSUE through DONE.
- access_num == 0: no controller request is issued. Grant for one cycle, then DONE with port_error.
- Watchdog:
  - Counts cycles in ISSUE and in XFER, restarting on each state entry.
  - On reaching TIMEOUT_CYCLES: drop the request and go to DONE with port_error.
  - A controller still busy then blocks the next grant until mem_idle returns.
- Request timing:
  - Requests dropped before grant are ignored.
  - A port_req that falls after grant does not abort; the transaction completes.
  - A port may re-request immediately after done, but loses priority to other pending ports.
- Simultaneous requests: the pointer decides priority.
- Single requester: back-to-back service with 1 IDLE cycle between transactions.
- Mid-operation reset: outputs drop asynchronously and the FSM returns to IDLE. The controller is reset by the same signal.

Test Plan:
- Port1 writes 1 word 0x00AB to 0x0400400, controller model raises write_flag for 1 cycle -> mem_write_request high in ISSUE only, wdata_ack[1] one pulse, done[1] one pulse, error 0.
- Ports 0, 1, 2 request reads simultaneously and continuously -> grants in order 0, 1, 2, 0; no two grants ever high together.
- Port0 reads 4 words, read_flag high 4 cycles with data 0x0011..0x0044 -> rdata_valid[0] 4 pulses carrying those values in order; rdata_valid[1:2] stay 0.
- access_num = 0 on port2 -> no mem request; done[2] and error[2] together, 2 cycles after the request is sampled.
- Flag never rises, TIMEOUT_CYCLES = 16 -> request drops after 16 cycles; error and done pulse; next grant waits for mem_idle.
- Reset asserted in XFER -> grant, requests and done go to 0 immediately; after release, port 0 is served first.
